multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS core. It replaces single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- It drives datapath selects, the shared instruction/data memory port handshake, and PC/IR/register-file write enables.
- Supported ops: add, sub, sll, jr, ori, lw, sw, lui, beq, j, jal, sb, sh, lb, lh, and custom load opcode 6'b111110.
- Ins == 0 retires as nop.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
Ins  in  32  current IR contents; stable from DECODE until retire
Zero  in  1  ALU equality flag, valid in EXEC
mem_ack  in  1  memory completes request this cycle
mem_req  out  1  memory request (FETCH, MEM)
IorD  out  1  0 = PC address, 1 = ALU result address
IRWrite  out  1  load IR
PCWrite  out  1  load PC
PCSource  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
RegDst  out  3  000 rt, 001 rd, 010 $31
AluSrc  out  1  0 = rt, 1 = extended immediate
AluControl  out  4  0000 add, 0001 sub, 0010 or, 0011 compare, 0100 sll
Sign  out  2  00 zero-ext, 01 sign-ext, 10 lui shift
WdSel  out  2  register write data: 00 ALU, 01 memory, 10 PC+4
RegWrite  out  1  register file write enable
MemRead  out  1  read strobe
MemWrite  out  1  write strobe
MemWriteOp  out  3  000 word, 001 byte, 010 half
MemReadOp  out  3  000 word, 001 byte, 010 half, 011 custom
illegal  out  1  one-cycle pulse, unsupported opcode/funct
retire  out  1  one-cycle pulse, instruction completes
instret  out  CNT_W  retired-instruction count
state  out  3  FSM state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB

Behaviour:
- **Reset (reset = 0, asynchronous):**
  - state = FETCH, instret = 0.
  - All other outputs forced to 0 combinationally while reset is low, including mem_req.
  - Reset mid-instruction abandons it: no retire, no instret increment.
- **Output timing:** all outputs except instret and state are combinational from state, Ins and Zero. Any output not listed for a state/op is 0.
- **FETCH:**
  - mem_req = 1, MemRead = 1, IorD = 0, MemReadOp = 000.
  - Hold while mem_ack = 0.
  - On mem_ack = 1: IRWrite = 1, PCWrite = 1, PCSource = 00, next state DECODE.
- **DECODE:**
  - Ins == 0: retire, go to FETCH.
  - j: PCWrite = 1, PCSource = 10, retire, go to FETCH.
  - jal: as j, plus RegWrite = 1, RegDst = 010, WdSel = 10. Retire, go to FETCH.
  - jr: PCWrite = 1, PCSource = 11, retire, go to FETCH.
  - Unsupported opcode/funct: illegal = 1, no retire, no instret increment, go to FETCH. The instruction behaves as a nop.
  - All other supported ops: go to EXEC.
- **EXEC:** AluSrc, AluControl and Sign per op.
  - R-type: AluSrc = 0, AluControl add/sub/sll.
  - ori: AluSrc = 1, AluControl = 0010, Sign = 00.
  - lui: AluSrc = 1, AluControl = 0000, Sign = 10.
  - Loads/stores: AluSrc = 1, AluControl = 0000, Sign = 01.
  - beq: AluControl = 0011, Sign = 01, PCSource = 01, PCWrite = Zero. Retire, go to FETCH.
  - R-type/ori/lui go to WB; loads/stores go to MEM.
- **MEM:**
  - mem_req = 1, IorD = 1, address path held as in EXEC.
  - Loads: MemRead = 1 with MemReadOp. Stores: MemWrite = 1 with MemWriteOp.
  - Hold while mem_ack = 0; MemWrite remains asserted during the wait.
  - On mem_ack: stores retire and go to FETCH; loads go to WB.
- **WB:**
  - RegWrite = 1.
  - RegDst = 001 for R-type, 000 otherwise.
  - WdSel = 01 for loads, 00 otherwise.
  - Retire, go to FETCH.
- **Retire and counter:**
  - retire = 1 exactly on the cycle the FSM leaves for FETCH with a completed instruction.
  - instret increments on that clock edge and wraps modulo 2^CNT_W.
- **Latency with mem_ack immediate:** j/jal/jr/nop 2 cycles; beq 3; sw/sb/sh 4; R-type/ori/lui 4; loads 5. Each memory wait cycle adds 1.
- **mem_ack outside FETCH/MEM:** ignored.
- **States 5–7:** unreachable. If entered, go to FETCH with all outputs 0.

Test Plan:
- Reset low mid-MEM of sw with mem_ack = 0: mem_req drops to 0 immediately, state = 0, instret = 0. After release, FETCH asserts mem_req = 1, IorD = 0.
- Fetch add $3,$1,$2 (0x00221820), mem_ack held low 3 cycles then high: FETCH lasts 4 cycles. WB shows RegWrite = 1, RegDst = 001, WdSel = 00, retire = 1, instret += 1.
- lw (0x8C430004), ack immediate: states 0→1→2→3→4, 5 cycles. EXEC has Sign = 01, AluSrc = 1. MEM has MemRead = 1, IorD = 1. WB has WdSel = 01.
- beq with Zero = 1 then Zero = 0: EXEC PCWrite = 1 with PCSource = 01, then PCWrite = 0. Both take 3 cycles and retire.
- jal 0x0C000010: DECODE drives PCWrite = 1, PCSource = 10, RegWrite = 1, RegDst = 010, WdSel = 10. Ins = 0xFC000000 gives illegal = 1, no retire, instret unchanged.
- Preload instret to all-ones via CNT_W = 4 and 16 retirements: count wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the multi-cycle sequencer and memory.
// The controller owns the request side; memory answers with a single-cycle ack.
interface multicycle_ctrl_if;
  logic       mem_req;
  logic       mem_ack;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic [2:0] MemReadOp;
  logic [2:0] MemWriteOp;

  modport master (
    output mem_req, IorD, MemRead, MemWrite, MemReadOp, MemWriteOp,
    input  mem_ack
  );

  modport slave (
    input  mem_req, IorD, MemRead, MemWrite, MemReadOp, MemWriteOp,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives datapath selects, the memory handshake and the retired-instruction count.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Ins,
  input  logic              Zero,
  multicycle_ctrl_if.master mem,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic [1:0]        PCSource,
  output logic [2:0]        RegDst,
  output logic              AluSrc,
  output logic [3:0]        AluControl,
  output logic [1:0]        Sign,
  output logic [1:0]        WdSel,
  output logic              RegWrite,
  output logic              illegal,
  output logic              retire,
  output logic [CNT_W-1:0]  instret,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t cur, nxt;

  logic [5:0] opcode, funct;
  logic       is_nop, is_add, is_sub, is_sll, is_rtype, is_jr, is_j, is_jal;
  logic       is_beq, is_ori, is_lui, is_load, is_store, is_legal;
  logic [2:0] rd_op, wr_op;

  always_comb begin
    opcode   = Ins[31:26];
    funct    = Ins[5:0];
    is_nop   = (Ins == 32'd0);
    is_add   = (opcode == 6'h00) && (funct == 6'h20);
    is_sub   = (opcode == 6'h00) && (funct == 6'h22);
    is_sll   = (opcode == 6'h00) && (funct == 6'h00) && !is_nop;
    is_rtype = is_add || is_sub || is_sll;
    is_jr    = (opcode == 6'h00) && (funct == 6'h08);
    is_j     = (opcode == 6'h02);
    is_jal   = (opcode == 6'h03);
    is_beq   = (opcode == 6'h04);
    is_ori   = (opcode == 6'h0D);
    is_lui   = (opcode == 6'h0F);
    is_load  = (opcode == 6'h23) || (opcode == 6'h20) || (opcode == 6'h21) || (opcode == 6'h3E);
    is_store = (opcode == 6'h2B) || (opcode == 6'h28) || (opcode == 6'h29);
    is_legal = is_nop || is_rtype || is_jr || is_j || is_jal || is_beq ||
               is_ori || is_lui || is_load || is_store;
    unique case (opcode)
      6'h20:   rd_op = 3'b001;
      6'h21:   rd_op = 3'b010;
      6'h3E:   rd_op = 3'b011;
      default: rd_op = 3'b000;
    endcase
    unique case (opcode)
      6'h28:   wr_op = 3'b001;
      6'h29:   wr_op = 3'b010;
      default: wr_op = 3'b000;
    endcase
  end

  // Outputs are a pure function of state/Ins/Zero and are held at zero while reset is low.
  always_comb begin
    mem.mem_req    = 1'b0;
    mem.IorD       = 1'b0;
    mem.MemRead    = 1'b0;
    mem.MemWrite   = 1'b0;
    mem.MemReadOp  = 3'b000;
    mem.MemWriteOp = 3'b000;
    IRWrite        = 1'b0;
    PCWrite        = 1'b0;
    PCSource       = 2'b00;
    RegDst         = 3'b000;
    AluSrc         = 1'b0;
    AluControl     = 4'b0000;
    Sign           = 2'b00;
    WdSel          = 2'b00;
    RegWrite       = 1'b0;
    illegal        = 1'b0;
    retire         = 1'b0;
    nxt            = cur;
    if (reset) begin
      case (cur)
        FETCH: begin
          mem.mem_req = 1'b1;
          mem.MemRead = 1'b1;
          if (mem.mem_ack) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            nxt     = DECODE;
          end
        end
        DECODE: begin
          nxt = FETCH;
          if (is_nop) begin
            retire = 1'b1;
          end else if (is_j || is_jal) begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            retire   = 1'b1;
            if (is_jal) begin
              RegWrite = 1'b1;
              RegDst   = 3'b010;
              WdSel    = 2'b10;
            end
          end else if (is_jr) begin
            PCWrite  = 1'b1;
            PCSource = 2'b11;
            retire   = 1'b1;
          end else if (!is_legal) begin
            illegal = 1'b1;
          end else begin
            nxt = EXEC;
          end
        end
        EXEC: begin
          nxt = FETCH;
          if (is_rtype) begin
            AluControl = is_sub ? 4'b0001 : (is_sll ? 4'b0100 : 4'b0000);
            nxt        = WB;
          end else if (is_ori) begin
            AluSrc     = 1'b1;
            AluControl = 4'b0010;
            nxt        = WB;
          end else if (is_lui) begin
            AluSrc = 1'b1;
            Sign   = 2'b10;
            nxt    = WB;
          end else if (is_load || is_store) begin
            AluSrc = 1'b1;
            Sign   = 2'b01;
            nxt    = MEM;
          end else if (is_beq) begin
            AluControl = 4'b0011;
            Sign       = 2'b01;
            PCSource   = 2'b01;
            PCWrite    = Zero;
            retire     = 1'b1;
          end
        end
        MEM: begin
          mem.mem_req = 1'b1;
          mem.IorD    = 1'b1;
          AluSrc      = 1'b1;
          Sign        = 2'b01;
          if (is_load) begin
            mem.MemRead   = 1'b1;
            mem.MemReadOp = rd_op;
          end
          if (is_store) begin
            mem.MemWrite   = 1'b1;
            mem.MemWriteOp = wr_op;
          end
          if (mem.mem_ack) begin
            retire = is_store;
            nxt    = is_store ? FETCH : WB;
          end
        end
        WB: begin
          RegWrite = 1'b1;
          RegDst   = is_rtype ? 3'b001 : 3'b000;
          WdSel    = is_load ? 2'b01 : 2'b00;
          retire   = 1'b1;
          nxt      = FETCH;
        end
        default: nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur     <= FETCH;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: the driver queues hand-computed per-cycle output
// vectors and a separate monitor pops and compares them on each falling edge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic [2:0] RegDst;
    logic       AluSrc;
    logic [3:0] AluControl;
    logic [1:0] Sign;
    logic [1:0] WdSel;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [2:0] MemWriteOp;
    logic [2:0] MemReadOp;
    logic       illegal;
    logic       retire;
    logic [2:0] state;
    logic [3:0] instret;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Ins;
  logic        Zero;
  logic        IRWrite, PCWrite, AluSrc, RegWrite, illegal, retire;
  logic [1:0]  PCSource, Sign, WdSel;
  logic [2:0]  RegDst, state;
  logic [3:0]  AluControl;
  logic [3:0]  instret;

  multicycle_ctrl_if mem ();

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Ins(Ins), .Zero(Zero), .mem(mem),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .RegDst(RegDst),
    .AluSrc(AluSrc), .AluControl(AluControl), .Sign(Sign), .WdSel(WdSel),
    .RegWrite(RegWrite), .illegal(illegal), .retire(retire),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [3:0] exp_count;
  exp_t  e;

  localparam logic [31:0] ADD_I  = 32'h00221820;
  localparam logic [31:0] SUB_I  = 32'h00221822;
  localparam logic [31:0] SLL_I  = 32'h00011100;
  localparam logic [31:0] LW_I   = 32'h8C430004;
  localparam logic [31:0] LH_I   = 32'h84220000;
  localparam logic [31:0] CUS_I  = 32'hF8220000;
  localparam logic [31:0] ORI_I  = 32'h34220005;
  localparam logic [31:0] LUI_I  = 32'h3C011234;
  localparam logic [31:0] BEQ_I  = 32'h10220003;
  localparam logic [31:0] JAL_I  = 32'h0C000010;
  localparam logic [31:0] J_I    = 32'h08000010;
  localparam logic [31:0] JR_I   = 32'h03E00008;
  localparam logic [31:0] ILL_I  = 32'hFC000000;
  localparam logic [31:0] ILLF_I = 32'h00000001;
  localparam logic [31:0] SB_I   = 32'hA0220000;
  localparam logic [31:0] SH_I   = 32'hA4220000;
  localparam logic [31:0] SW_I   = 32'hAC220000;

  function automatic exp_t mk(input logic [2:0] s);
    exp_t v;
    v = '0;
    v.state = s;
    return v;
  endfunction

  function automatic exp_t fetchVec(input logic ack);
    exp_t v;
    v = mk(3'd0);
    v.mem_req = 1'b1;
    v.MemRead = 1'b1;
    v.IRWrite = ack;
    v.PCWrite = ack;
    return v;
  endfunction

  function automatic exp_t sampleDut();
    exp_t v;
    v.mem_req    = mem.mem_req;
    v.IorD       = mem.IorD;
    v.IRWrite    = IRWrite;
    v.PCWrite    = PCWrite;
    v.PCSource   = PCSource;
    v.RegDst     = RegDst;
    v.AluSrc     = AluSrc;
    v.AluControl = AluControl;
    v.Sign       = Sign;
    v.WdSel      = WdSel;
    v.RegWrite   = RegWrite;
    v.MemRead    = mem.MemRead;
    v.MemWrite   = mem.MemWrite;
    v.MemWriteOp = mem.MemWriteOp;
    v.MemReadOp  = mem.MemReadOp;
    v.illegal    = illegal;
    v.retire     = retire;
    v.state      = state;
    v.instret    = instret;
    return v;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show during that cycle.
  task automatic applyStimulus(input string name, input logic [31:0] ins, input logic z,
                               input logic ack, input exp_t v);
    Ins          = ins;
    Zero         = z;
    mem.mem_ack  = ack;
    v.instret    = exp_count;
    exp_q.push_back(v);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    if (v.retire) exp_count = exp_count + 4'd1;
  endtask

  task automatic checkOutput();
    exp_t  want, got;
    string n;
    want = exp_q.pop_front();
    n    = name_q.pop_front();
    got  = sampleDut();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", n, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput();
  end

  initial begin
    reset       = 1'b0;
    Ins         = 32'd0;
    Zero        = 1'b0;
    mem.mem_ack = 1'b0;
    exp_count   = 4'd0;
    @(posedge clk);
    #1;
    applyStimulus("reset", 32'd0, 1'b0, 1'b1, mk(3'd0));
    reset = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus("add fetch wait", ADD_I, 1'b0, 1'b0, fetchVec(1'b0));
    applyStimulus("add fetch ack", ADD_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("add decode", ADD_I, 1'b0, 1'b1, mk(3'd1));
    applyStimulus("add exec", ADD_I, 1'b0, 1'b1, mk(3'd2));
    e = mk(3'd4); e.RegWrite = 1'b1; e.RegDst = 3'b001; e.retire = 1'b1;
    applyStimulus("add wb", ADD_I, 1'b0, 1'b1, e);

    applyStimulus("sub fetch", SUB_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("sub decode", SUB_I, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2); e.AluControl = 4'b0001;
    applyStimulus("sub exec", SUB_I, 1'b0, 1'b0, e);
    e = mk(3'd4); e.RegWrite = 1'b1; e.RegDst = 3'b001; e.retire = 1'b1;
    applyStimulus("sub wb", SUB_I, 1'b0, 1'b0, e);

    applyStimulus("sll fetch", SLL_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("sll decode", SLL_I, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2); e.AluControl = 4'b0100;
    applyStimulus("sll exec", SLL_I, 1'b0, 1'b0, e);
    e = mk(3'd4); e.RegWrite = 1'b1; e.RegDst = 3'b001; e.retire = 1'b1;
    applyStimulus("sll wb", SLL_I, 1'b0, 1'b0, e);

    applyStimulus("lw fetch", LW_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("lw decode", LW_I, 1'b0, 1'b1, mk(3'd1));
    e = mk(3'd2); e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("lw exec", LW_I, 1'b0, 1'b1, e);
    e = mk(3'd3); e.mem_req = 1'b1; e.IorD = 1'b1; e.MemRead = 1'b1; e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("lw mem", LW_I, 1'b0, 1'b1, e);
    e = mk(3'd4); e.RegWrite = 1'b1; e.WdSel = 2'b01; e.retire = 1'b1;
    applyStimulus("lw wb", LW_I, 1'b0, 1'b1, e);

    applyStimulus("lh fetch", LH_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("lh decode", LH_I, 1'b0, 1'b1, mk(3'd1));
    e = mk(3'd2); e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("lh exec", LH_I, 1'b0, 1'b1, e);
    e = mk(3'd3); e.mem_req = 1'b1; e.IorD = 1'b1; e.MemRead = 1'b1; e.MemReadOp = 3'b010;
    e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("lh mem", LH_I, 1'b0, 1'b1, e);
    e = mk(3'd4); e.RegWrite = 1'b1; e.WdSel = 2'b01; e.retire = 1'b1;
    applyStimulus("lh wb", LH_I, 1'b0, 1'b1, e);

    applyStimulus("custom fetch", CUS_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("custom decode", CUS_I, 1'b0, 1'b1, mk(3'd1));
    e = mk(3'd2); e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("custom exec", CUS_I, 1'b0, 1'b1, e);
    e = mk(3'd3); e.mem_req = 1'b1; e.IorD = 1'b1; e.MemRead = 1'b1; e.MemReadOp = 3'b011;
    e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("custom mem", CUS_I, 1'b0, 1'b1, e);
    e = mk(3'd4); e.RegWrite = 1'b1; e.WdSel = 2'b01; e.retire = 1'b1;
    applyStimulus("custom wb", CUS_I, 1'b0, 1'b1, e);

    applyStimulus("ori fetch", ORI_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("ori decode", ORI_I, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2); e.AluSrc = 1'b1; e.AluControl = 4'b0010;
    applyStimulus("ori exec", ORI_I, 1'b0, 1'b0, e);
    e = mk(3'd4); e.RegWrite = 1'b1; e.retire = 1'b1;
    applyStimulus("ori wb", ORI_I, 1'b0, 1'b0, e);

    applyStimulus("lui fetch", LUI_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("lui decode", LUI_I, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2); e.AluSrc = 1'b1; e.Sign = 2'b10;
    applyStimulus("lui exec", LUI_I, 1'b0, 1'b0, e);
    e = mk(3'd4); e.RegWrite = 1'b1; e.retire = 1'b1;
    applyStimulus("lui wb", LUI_I, 1'b0, 1'b0, e);

    for (int z = 1; z >= 0; z--) begin
      applyStimulus("beq fetch", BEQ_I, 1'b0, 1'b1, fetchVec(1'b1));
      applyStimulus("beq decode", BEQ_I, 1'b0, 1'b0, mk(3'd1));
      e = mk(3'd2); e.AluControl = 4'b0011; e.Sign = 2'b01; e.PCSource = 2'b01;
      e.PCWrite = (z == 1); e.retire = 1'b1;
      applyStimulus(z == 1 ? "beq exec taken" : "beq exec not taken", BEQ_I, z[0], 1'b1, e);
    end

    applyStimulus("jal fetch", JAL_I, 1'b0, 1'b1, fetchVec(1'b1));
    e = mk(3'd1); e.PCWrite = 1'b1; e.PCSource = 2'b10; e.RegWrite = 1'b1;
    e.RegDst = 3'b010; e.WdSel = 2'b10; e.retire = 1'b1;
    applyStimulus("jal decode", JAL_I, 1'b0, 1'b0, e);

    applyStimulus("j fetch", J_I, 1'b0, 1'b1, fetchVec(1'b1));
    e = mk(3'd1); e.PCWrite = 1'b1; e.PCSource = 2'b10; e.retire = 1'b1;
    applyStimulus("j decode", J_I, 1'b0, 1'b0, e);

    applyStimulus("jr fetch", JR_I, 1'b0, 1'b1, fetchVec(1'b1));
    e = mk(3'd1); e.PCWrite = 1'b1; e.PCSource = 2'b11; e.retire = 1'b1;
    applyStimulus("jr decode", JR_I, 1'b0, 1'b0, e);

    applyStimulus("nop fetch", 32'd0, 1'b0, 1'b1, fetchVec(1'b1));
    e = mk(3'd1); e.retire = 1'b1;
    applyStimulus("nop decode", 32'd0, 1'b0, 1'b1, e);

    applyStimulus("illegal op fetch", ILL_I, 1'b0, 1'b1, fetchVec(1'b1));
    e = mk(3'd1); e.illegal = 1'b1;
    applyStimulus("illegal op decode", ILL_I, 1'b0, 1'b1, e);
    applyStimulus("illegal funct fetch", ILLF_I, 1'b0, 1'b1, fetchVec(1'b1));
    e = mk(3'd1); e.illegal = 1'b1;
    applyStimulus("illegal funct decode", ILLF_I, 1'b0, 1'b1, e);

    applyStimulus("sb fetch", SB_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("sb decode", SB_I, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2); e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("sb exec", SB_I, 1'b0, 1'b0, e);
    e = mk(3'd3); e.mem_req = 1'b1; e.IorD = 1'b1; e.MemWrite = 1'b1; e.MemWriteOp = 3'b001;
    e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("sb mem wait", SB_I, 1'b0, 1'b0, e);
    e.retire = 1'b1;
    applyStimulus("sb mem ack", SB_I, 1'b0, 1'b1, e);

    applyStimulus("sh fetch", SH_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("sh decode", SH_I, 1'b0, 1'b1, mk(3'd1));
    e = mk(3'd2); e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("sh exec", SH_I, 1'b0, 1'b1, e);
    e = mk(3'd3); e.mem_req = 1'b1; e.IorD = 1'b1; e.MemWrite = 1'b1; e.MemWriteOp = 3'b010;
    e.AluSrc = 1'b1; e.Sign = 2'b01; e.retire = 1'b1;
    applyStimulus("sh mem", SH_I, 1'b0, 1'b1, e);

    // Abandon a store stalled in MEM; the count must clear and nothing retires.
    applyStimulus("sw fetch", SW_I, 1'b0, 1'b1, fetchVec(1'b1));
    applyStimulus("sw decode", SW_I, 1'b0, 1'b0, mk(3'd1));
    e = mk(3'd2); e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("sw exec", SW_I, 1'b0, 1'b0, e);
    e = mk(3'd3); e.mem_req = 1'b1; e.IorD = 1'b1; e.MemWrite = 1'b1;
    e.AluSrc = 1'b1; e.Sign = 2'b01;
    applyStimulus("sw mem wait", SW_I, 1'b0, 1'b0, e);
    reset     = 1'b0;
    exp_count = 4'd0;
    applyStimulus("reset mid-mem", SW_I, 1'b0, 1'b0, mk(3'd0));
    reset = 1'b1;
    applyStimulus("fetch after reset", 32'd0, 1'b0, 1'b0, fetchVec(1'b0));

    for (int i = 0; i < 16; i++) begin
      applyStimulus("wrap nop fetch", 32'd0, 1'b0, 1'b1, fetchVec(1'b1));
      e = mk(3'd1); e.retire = 1'b1;
      applyStimulus("wrap nop decode", 32'd0, 1'b0, 1'b1, e);
    end
    applyStimulus("instret wrapped", 32'd0, 1'b0, 1'b0, fetchVec(1'b0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
